// File: rtl/uart_receiver.sv
// 8N1 UART deframer on a 16x oversample tick: 2-flop synchronizer, mid-bit sampling, break recovery.
// Latency: rx_done_o rises 1 clk after the stop-bit midpoint tick (SAMPLE_TICKS/2 + (WORD_BITS+1)*SAMPLE_TICKS ticks after start detect).
// Backpressure: none; the consumer must take data_o on the single-cycle rx_done_o strobe.
module uart_receiver #(
    parameter int WORD_BITS    = 8,
    parameter int SAMPLE_TICKS = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 baud_i,
    input  logic                 rx_i,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 rx_done_o,
    output logic                 frame_err_o
);

    localparam int S_W = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam int N_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [S_W-1:0] S_HALF = S_W'(SAMPLE_TICKS / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SAMPLE_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_RECOVER
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [WORD_BITS-1:0] b_q, b_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 rx_s;

    assign rx_s        = sync_q[1];
    assign data_o      = data_q;
    assign rx_done_o   = done_q;
    assign frame_err_o = err_q;

    always_comb begin
        sync_d  = {sync_q[0], rx_i};
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (baud_i) begin
                    if (s_q == S_HALF) begin
                        // Line high at the start midpoint is a glitch, not a frame.
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_i) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[WORD_BITS-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_i) begin
                    if (s_q == S_LAST) begin
                        data_d  = b_q;
                        done_d  = 1'b1;
                        err_d   = ~rx_s;
                        state_d = rx_s ? ST_IDLE : ST_RECOVER;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                // A held-low line (break) must go high before a new start is accepted.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            sync_q  <= 2'b11;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of single frames plus hand-written multi-frame corner sequences.
module tb_uart_receiver;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;
    logic       baud_i  = 1'b0;
    logic       rx_i    = 1'b1;
    logic [7:0] data_o;
    logic       rx_done_o;
    logic       frame_err_o;

    uart_receiver #(.WORD_BITS(8), .SAMPLE_TICKS(16)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .baud_i      (baud_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .rx_done_o   (rx_done_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int tick_div = 4;
    int tcnt     = 0;
    int cyc      = 0;
    int total    = 0;
    int bad      = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int wide_cnt  = 0;
    logic prev_done = 1'b0;
    logic [8:0] rxq[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Oversample tick: one high clock every tick_div clocks (tick_div=1 holds it high).
    always @(negedge clk_i) begin
        baud_i = (tcnt == 0);
        tcnt   = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
    end

    always @(negedge clk_i) begin
        if (rx_done_o) begin
            rxq.push_back({frame_err_o, data_o});
            done_cyc = cyc;
            if (prev_done) wide_cnt++;
        end
        prev_done = rx_done_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string name, input int idx, input logic err, input logic [7:0] d);
        logic [31:0] act;
        act = (idx < rxq.size()) ? {23'd0, rxq[idx]} : 32'hDEAD;
        check(name, act, {23'd0, err, d});
    endtask

    task automatic drive(input logic v, input int nbits);
        rx_i = v;
        repeat (nbits * 16 * tick_div) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive(1'b0, 1);
        for (int i = 0; i < 8; i++) drive(d[i], 1);
        drive(stop, 1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         div;
        logic [7:0] exp_d;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{d: 8'h55, stop: 1'b1, div: 4, exp_d: 8'h55, exp_err: 1'b0};
        vecs[1] = '{d: 8'h00, stop: 1'b1, div: 4, exp_d: 8'h00, exp_err: 1'b0};
        vecs[2] = '{d: 8'hFF, stop: 1'b1, div: 4, exp_d: 8'hFF, exp_err: 1'b0};
        vecs[3] = '{d: 8'h96, stop: 1'b1, div: 1, exp_d: 8'h96, exp_err: 1'b0};
        vecs[4] = '{d: 8'hC3, stop: 1'b0, div: 4, exp_d: 8'hC3, exp_err: 1'b1};
        vecs[5] = '{d: 8'h01, stop: 1'b1, div: 2, exp_d: 8'h01, exp_err: 1'b0};

        // Reset held with line idle
        repeat (5) @(negedge clk_i);
        check("reset_during", {23'd0, data_o, rx_done_o, frame_err_o}, 32'd0);
        repeat (5) @(negedge clk_i);
        reset_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("reset_after", {23'd0, data_o, rx_done_o, frame_err_o}, 32'd0);
        check("reset_no_pulse", rxq.size(), 0);

        for (int i = 0; i < 6; i++) begin
            rxq.delete();
            tick_div = vecs[i].div;
            drive(1'b1, 1);
            send_frame(vecs[i].d, vecs[i].stop);
            drive(1'b1, 2);
            check($sformatf("vec%0d_count", i), rxq.size(), 1);
            check_entry($sformatf("vec%0d_word", i), 0, vecs[i].exp_err, vecs[i].exp_d);
            if (i == 0)
                check("vec0_latency", {31'd0, (done_cyc - start_cyc >= 600) && (done_cyc - start_cyc <= 620)}, 1);
        end
        check("hold_between_frames", {23'd0, frame_err_o, data_o}, {23'd0, 1'b0, 8'h01});

        tick_div = 4;
        drive(1'b1, 1);

        // Back-to-back frames, no idle gap
        rxq.delete();
        send_frame(8'hCC, 1'b1);
        send_frame(8'h3A, 1'b1);
        drive(1'b1, 2);
        check("b2b_count", rxq.size(), 2);
        check_entry("b2b_first", 0, 1'b0, 8'hCC);
        check_entry("b2b_second", 1, 1'b0, 8'h3A);

        // Start glitch of 3 ticks, then a good frame
        rxq.delete();
        rx_i = 1'b0;
        repeat (3 * tick_div) @(negedge clk_i);
        drive(1'b1, 2);
        check("glitch_no_pulse", rxq.size(), 0);
        send_frame(8'hA5, 1'b1);
        drive(1'b1, 2);
        check("glitch_then_count", rxq.size(), 1);
        check_entry("glitch_then_word", 0, 1'b0, 8'hA5);

        // Framing error followed by a break of 3 frame times
        rxq.delete();
        send_frame(8'hF0, 1'b0);
        drive(1'b0, 30);
        check("break_count", rxq.size(), 1);
        check_entry("break_word", 0, 1'b1, 8'hF0);
        drive(1'b1, 2);
        send_frame(8'h81, 1'b1);
        drive(1'b1, 2);
        check("after_break_count", rxq.size(), 2);
        check_entry("after_break_word", 1, 1'b0, 8'h81);

        // Reset in the middle of data bit 4 of 0xFF
        rxq.delete();
        drive(1'b0, 1);
        drive(1'b1, 4);
        repeat (8 * tick_div) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("midreset_outputs", {23'd0, data_o, rx_done_o, frame_err_o}, 32'd0);
        rx_i = 1'b1;
        repeat (10) @(negedge clk_i);
        reset_i = 1'b1;
        drive(1'b1, 2);
        check("midreset_no_pulse", rxq.size(), 0);
        send_frame(8'h0F, 1'b1);
        drive(1'b1, 2);
        check("midreset_then_count", rxq.size(), 1);
        check_entry("midreset_then_word", 0, 1'b0, 8'h0F);

        check("pulse_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path, the counterpart of `uart_transmitter`. Samples the serial line using the shared 16x-oversampling tick from `baud_generator` and deframes 8N1 characters: idle high, start low, LSB first, stop high. Presents each received word with a one-cycle done strobe and a framing-error flag for the downstream consumer, such as the Morse encoder front-end.

## Interface
- `WORD_BITS`, 8, data bits per frame.
- `SAMPLE_TICKS`, 16, baud ticks per bit period; must be even and ≥4.

- `clk_i`  in  1  system clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `baud_i`  in  1  oversample tick from `baud_generator`; one-`clk_i` pulse, SAMPLE_TICKS per bit.
- `rx_i`  in  1  asynchronous serial input.
- `data_o`  out  WORD_BITS  last received word; registered.
- `rx_done_o`  out  1  one-cycle pulse when a frame completes.
- `frame_err_o`  out  1  stop-bit status of the last frame; 1 means the stop bit sampled low.

## Operation
- `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- Registers:
  - tick counter `s`: width $clog2(SAMPLE_TICKS).
  - bit counter `n`: width $clog2(WORD_BITS).
  - shift register `b`: WORD_BITS.
- Counters advance only in cycles where `baud_i`=1.
- States:
  - IDLE: when `rx_s`=0, go to START with s←0.
  - START: on each tick, if s==SAMPLE_TICKS/2−1, check the line. If `rx_s`=0, go to DATA with s←0, n←0. If `rx_s`=1, treat it as a glitch and return to IDLE. Otherwise s←s+1.
  - DATA: on each tick, if s==SAMPLE_TICKS−1, then s←0 and b←{rx_s, b[WORD_BITS-1:1]} (LSB first). If n==WORD_BITS−1, go to STOP; else n←n+1. Otherwise s←s+1.
  - STOP: on each tick, if s==SAMPLE_TICKS−1:
    - data_o←b, rx_done_o←1 for one cycle, frame_err_o←~rx_s.
    - If `rx_s`=1, go to IDLE; else go to RECOVER.
  - RECOVER: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- `data_o` and `frame_err_o` change only on the done cycle and otherwise hold their values.
- Input bits are sampled at the middle of each bit: every sample after the start check is SAMPLE_TICKS ticks apart.

## Timing
- Reset values:
  - data_o=0, rx_done_o=0, frame_err_o=0.
  - state=IDLE, s=0, n=0, b=0, synchronizer=1.
- Reset is asynchronous in both directions. Asserting it mid-frame aborts the frame with no done pulse.
- Input latency: a change on `rx_i` is visible on `rx_s` after 2 clocks.
- Frame latency: `rx_done_o` rises in the clock after the baud tick at which the stop-bit midpoint is sampled. That is SAMPLE_TICKS/2 + (WORD_BITS+1)·SAMPLE_TICKS ticks after the start edge is detected; with defaults, 152 ticks ≈ 9.5 bit times.
- `rx_done_o` is exactly one `clk_i` wide, irrespective of the baud tick spacing.
- Back-to-back frames: the receiver is in IDLE after the stop sample, half a bit before the next start edge. No character is lost with zero inter-frame gap.
- Back-to-back ticks: `baud_i` held high on consecutive clocks is legal; each high cycle counts once.
- `rx_i` changes between ticks have no effect except through the sample points and IDLE detection.

## Test plan
Run at 100 MHz with `baud_generator` M=651 (9600 baud; 1 bit = 10416 clocks). The serial stimulus is driven by `uart_transmitter` or a behavioural driver.

- Reset: hold `reset_i`=0 with rx idle for 10 clocks -> data_o=0x00, rx_done_o=0, frame_err_o=0 during and after reset.
- Single frame 0x55 -> exactly one rx_done_o pulse of 1 clock, about 9.5 bit times after the start edge; data_o=0x55, frame_err_o=0.
- Back-to-back 0xCC then 0x3A with no idle gap -> two pulses, data_o=0xCC then 0x3A, frame_err_o=0 both times.
- Start glitch: rx low for 3 ticks, then high -> no pulse, state returns to IDLE. A following 0xA5 is received correctly.
- Framing error/break: frame 0xF0 with stop bit low, then rx held low for 3 frame times.
  - Expect one pulse with data_o=0xF0, frame_err_o=1, and no further pulses while low.
  - After rx returns high, a 0x81 frame gives data_o=0x81, frame_err_o=0.
- Reset mid-frame: assert reset during bit 4 of 0xFF -> outputs return to reset values immediately and no pulse occurs. After release, a 0x0F frame is received correctly.
